// File: rtl/lsu_request_pkg.sv
// Shared core types for the data-memory request path.
// LSU_MISALIGN_FAULT_EN adds the FAULT state and misalignment trapping.
package lsu_request_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

`ifdef LSU_MISALIGN_FAULT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_FAULT} lsu_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} lsu_state_t;
`endif

    // Byte lane the access starts on; low bits a size cannot use are dropped.
    function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return off;
            2'd1:    return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size, input logic [XLEN-1:0] wdata);
        case (size)
            2'd0:    return {4{wdata[7:0]}};
            2'd1:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'b00) || (size == 2'd3);
    endfunction

endpackage

// File: rtl/lsu_request_if.sv
// req/gnt/rvalid data-memory port; master is the LSU, slave is the memory.
interface lsu_request_if;
    import lsu_request_pkg::*;

    logic            mem_req;
    logic            mem_gnt;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_request_load_align.sv
// Load data alignment: shift lane down, mask to size, sign/zero extend.
// Purely combinational; no flow control.
module lsu_load_align
    import lsu_request_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  mem_size_t       size,
    input  logic            uns,
    output logic [XLEN-1:0] word
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        word    = shifted;
        case (size)
            SIZE_BYTE: word = {{(XLEN-8){~uns & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: word = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
            default:   word = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_request.sv
// Data-memory initiator: one access in flight, response 3 cycles after accept minimum.
// req_ready only in IDLE; gnt/rvalid stalls extend latency. Macro: LSU_MISALIGN_FAULT_EN.
module lsu_request
    import lsu_request_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault,
    lsu_request_if.master     mem
);

    lsu_state_t      state, state_nxt;
    logic            write_q;
    mem_size_t       size_q;
    logic            uns_q;
    logic [1:0]      off_q;
    logic            accept;
    logic            bad_req;
    mem_size_t       size_in;
    logic [XLEN-1:0] load_word;

    assign accept  = req_valid && req_ready;
    assign size_in = (req_size == 2'd3) ? SIZE_WORD : mem_size_t'(req_size);

`ifdef LSU_MISALIGN_FAULT_EN
    assign bad_req = misaligned(req_size, req_addr[1:0]);
`else
    assign bad_req = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        mem.mem_req = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = bad_req ? lsu_state_t'(2'd3) : ST_REQ;
            end
            ST_REQ: begin
                mem.mem_req = 1'b1;
                if (mem.mem_gnt) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    lsu_load_align u_align (
        .rdata  (mem.mem_rdata),
        .offset (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .word   (load_word)
    );

    logic fault_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            write_q       <= 1'b0;
            size_q        <= SIZE_BYTE;
            uns_q         <= 1'b0;
            off_q         <= 2'b00;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= 4'b0000;
            mem.mem_wdata <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            fault_q       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (accept) begin
                write_q       <= req_write;
                size_q        <= size_in;
                uns_q         <= req_unsigned;
                off_q         <= eff_offset(size_in, req_addr[1:0]);
                mem.mem_we    <= req_write;
                mem.mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                mem.mem_be    <= byte_en(size_in, req_addr[1:0]);
                mem.mem_wdata <= store_lanes(size_in, req_wdata);
            end
            if (state == ST_WAIT && mem.mem_rvalid) begin
                resp_valid <= 1'b1;
                resp_rdata <= write_q ? '0 : load_word;
                fault_q    <= 1'b0;
            end
`ifdef LSU_MISALIGN_FAULT_EN
            if (state == ST_FAULT) begin
                resp_valid <= 1'b1;
                resp_rdata <= '0;
                fault_q    <= 1'b1;
            end
`endif
        end
    end

`ifdef LSU_MISALIGN_FAULT_EN
    assign resp_fault = fault_q;
`else
    assign resp_fault = 1'b0;
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

endmodule

// File: tb/tb_lsu_request.sv
// Directed bench for lsu_request: loads, stores, stalls, back-to-back and reset abort.
module tb_lsu_request;
    import lsu_request_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;

    int checks = 0;
    int errors = 0;

`ifdef LSU_MISALIGN_FAULT_EN
    localparam bit FLT_EN = 1'b1;
`else
    localparam bit FLT_EN = 1'b0;
`endif

    lsu_request_if mem();

    lsu_request dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem          (mem)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts in the cycle the request is presented; returns in the response cycle.
    task automatic txn(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int gd, input int rd, input logic [31:0] rdata,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                       input bit exp_flt);
        chk({tag, ":ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_write = ~wr; req_size = 2'd0; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        if (exp_flt) begin
            chk({tag, ":flt_noreq"}, {31'b0, mem.mem_req}, 32'd0);
            tick();
            chk({tag, ":flt_vld"}, {31'b0, resp_valid}, 32'd1);
            chk({tag, ":flt_flag"}, {31'b0, resp_fault}, 32'd1);
            chk({tag, ":flt_rdata"}, resp_rdata, 32'd0);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            chk({tag, ":req"}, {31'b0, mem.mem_req}, 32'd1);
            chk({tag, ":addr"}, mem.mem_addr, exp_addr);
            chk({tag, ":be"}, {28'b0, mem.mem_be}, {28'b0, exp_be});
            chk({tag, ":we"}, {31'b0, mem.mem_we}, {31'b0, wr});
            chk({tag, ":wdata"}, mem.mem_wdata, exp_wdata);
            chk({tag, ":busy"}, {31'b0, req_ready}, 32'd0);
            chk({tag, ":early_resp"}, {31'b0, resp_valid}, 32'd0);
            mem.mem_gnt = (i == gd);
            tick();
        end
        mem.mem_gnt = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            chk({tag, ":req_low"}, {31'b0, mem.mem_req}, 32'd0);
            chk({tag, ":early_resp"}, {31'b0, resp_valid}, 32'd0);
            mem.mem_rvalid = (i == rd);
            mem.mem_rdata  = (i == rd) ? rdata : 32'h0BAD_0BAD;
            tick();
        end
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = 32'h0BAD_0BAD;
        chk({tag, ":resp_vld"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, ":resp_rdata"}, resp_rdata, exp_rdata);
        chk({tag, ":resp_fault"}, {31'b0, resp_fault}, 32'd0);
        chk({tag, ":ready_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic idle_after(input string tag);
        tick();
        chk({tag, ":single_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        tick();
        tick();
        chk("rst:req", {31'b0, mem.mem_req}, 32'd0);
        chk("rst:addr", mem.mem_addr, 32'd0);
        chk("rst:be", {28'b0, mem.mem_be}, 32'd0);
        chk("rst:wdata", mem.mem_wdata, 32'd0);
        chk("rst:resp_vld", {31'b0, resp_valid}, 32'd0);
        chk("rst:resp_rdata", resp_rdata, 32'd0);
        chk("rst:ready", {31'b0, req_ready}, 32'd1);
        reset = 1'b0;
        tick();

        txn("lb1001", 1'b0, 2'd0, 1'b0, 32'h0000_1001, 32'h0, 0, 0, 32'h1280_3456,
            32'h0000_1000, 4'b0010, 32'h0, 32'h0000_0034, 1'b0);
        idle_after("lb1001");
        txn("lbu1002", 1'b0, 2'd0, 1'b1, 32'h0000_1002, 32'h0, 0, 0, 32'h1280_3456,
            32'h0000_1000, 4'b0100, 32'h0, 32'h0000_0080, 1'b0);
        idle_after("lbu1002");
        txn("lb1002", 1'b0, 2'd0, 1'b0, 32'h0000_1002, 32'h0, 0, 0, 32'h1280_3456,
            32'h0000_1000, 4'b0100, 32'h0, 32'hFFFF_FF80, 1'b0);
        idle_after("lb1002");
        txn("sh2002", 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 32'hDEAD_BEEF,
            32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
        idle_after("sh2002");
        txn("sb_lane3", 1'b1, 2'd0, 1'b0, 32'h0000_2003, 32'h0000_00E7, 1, 0, 32'h0,
            32'h0000_2000, 4'b1000, 32'hE7E7_E7E7, 32'h0, 1'b0);
        idle_after("sb_lane3");

        // stalled word load, then a half load presented in the response cycle
        txn("lw_stall", 1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 3, 2, 32'hCAFE_F00D,
            32'h0000_4000, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
        txn("lh_b2b", 1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'h0, 0, 0, 32'h8001_1234,
            32'h0000_4000, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0);
        idle_after("lh_b2b");
        txn("lhu4000", 1'b0, 2'd1, 1'b1, 32'h0000_4000, 32'h0, 0, 1, 32'h00FF_F00F,
            32'h0000_4000, 4'b0011, 32'h0, 32'h0000_F00F, 1'b0);
        idle_after("lhu4000");

        txn("lw3002", 1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0, 0, 0, 32'h1122_3344,
            32'h0000_3000, 4'b1111, 32'h0, 32'h1122_3344, FLT_EN);
        idle_after("lw3002");
        txn("size3", 1'b0, 2'd3, 1'b0, 32'h0000_5001, 32'h0, 0, 0, 32'hA5A5_1234,
            32'h0000_5000, 4'b1111, 32'h0, 32'hA5A5_1234, FLT_EN);
        idle_after("size3");

        // reset while waiting for rvalid; the late rvalid must be dropped
        chk("rstwait:ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_6000;
        tick();
        req_valid = 1'b0;
        chk("rstwait:req", {31'b0, mem.mem_req}, 32'd1);
        mem.mem_gnt = 1'b1;
        tick();
        mem.mem_gnt = 1'b0;
        chk("rstwait:in_wait", {31'b0, mem.mem_req}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstwait:req_drop", {31'b0, mem.mem_req}, 32'd0);
        chk("rstwait:ready_idle", {31'b0, req_ready}, 32'd1);
        mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h7777_7777;
        tick();
        mem.mem_rvalid = 1'b0;
        chk("rstwait:no_resp", {31'b0, resp_valid}, 32'd0);
        chk("rstwait:ready_after", {31'b0, req_ready}, 32'd1);
        chk("rstwait:req_after", {31'b0, mem.mem_req}, 32'd0);
        tick();
        chk("rstwait:no_resp2", {31'b0, resp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
